// File: rtl/stack_cpu_pkg.sv
// Shared types and constants for the parametrised stack CPU core.
package stack_cpu_pkg;

   localparam int unsigned OpcodeW = 3;

   typedef enum logic [2:0] {
      OpAdd  = 3'b000,
      OpSub  = 3'b001,
      OpAnd  = 3'b010,
      OpNot  = 3'b011,
      OpPush = 3'b100,
      OpPop  = 3'b101,
      OpJmp  = 3'b110,
      OpJz   = 3'b111
   } opcode_e;

   typedef logic [2:0] state_t;

   localparam state_t StFetch  = 3'd0;
   localparam state_t StDecode = 3'd1;
   localparam state_t StPopA   = 3'd2;
   localparam state_t StPopB   = 3'd3;
   localparam state_t StExec   = 3'd4;
   localparam state_t StMemRd  = 3'd5;
   localparam state_t StMemWr  = 3'd6;
   localparam state_t StHalt   = 3'd7;

endpackage

// File: rtl/hw_stack.sv
// LIFO operand stack; pointer wraps modulo STACK_DEPTH, occupancy count saturates.
module hw_stack #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] tos,
   output logic              full,
   output logic              empty
);

   localparam int unsigned IdxW = $clog2(STACK_DEPTH);
   localparam logic [IdxW:0] FullCnt = (IdxW + 1)'(STACK_DEPTH);

   logic [DATA_W-1:0] mem_q [STACK_DEPTH];
   logic [IdxW-1:0]   ptr_q;
   logic [IdxW-1:0]   top_idx;
   logic [IdxW:0]     cnt_q;

   assign top_idx = ptr_q - 1'b1;
   assign tos     = mem_q[top_idx];
   assign full    = (cnt_q == FullCnt);
   assign empty   = (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else if (push) begin
         ptr_q <= ptr_q + 1'b1;
         if (!full) cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
         ptr_q <= ptr_q - 1'b1;
         if (!empty) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Storage carries no reset; the occupancy count defines what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[ptr_q] <= din;
   end

endmodule

// File: rtl/stack_cpu_core.sv
// Multicycle stack-machine core with a single ready-handshaked memory port.
// Define STACK_CPU_STACK_CHECK_EN to enable overflow/underflow detection and HALT.
module stack_cpu_core
   import stack_cpu_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned STACK_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic              stack_err
);

`ifdef STACK_CPU_STACK_CHECK_EN
   localparam bit CheckEn = 1'b1;
`else
   localparam bit CheckEn = 1'b0;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   opcode_e           op_q, op_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              halted_q, halted_d;
   logic              err_q, err_d;

   logic              st_push, st_pop, st_full, st_empty;
   logic [DATA_W-1:0] st_din, st_tos;
   logic              fetch_next, fault;

   hw_stack #(
      .DATA_W      (DATA_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (st_push),
      .pop   (st_pop),
      .din   (st_din),
      .tos   (st_tos),
      .full  (st_full),
      .empty (st_empty)
   );

   function automatic logic [DATA_W-1:0] alu(input opcode_e op, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      case (op)
         OpAdd:   return b + a;
         OpSub:   return b - a;
         OpAnd:   return b & a;
         default: return ~a;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      op_d       = op_q;
      adr_d      = adr_q;
      a_d        = a_q;
      b_d        = b_q;
      re_d       = re_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      halted_d   = halted_q;
      err_d      = err_q;
      st_push    = 1'b0;
      st_pop     = 1'b0;
      st_din     = mem_rdata;
      fetch_next = 1'b0;
      fault      = 1'b0;

      case (state_q)
         StFetch: begin
            // Only after reset does FETCH arrive without the request already raised.
            if (!re_q) begin
               re_d   = 1'b1;
               addr_d = pc_q;
            end else if (mem_ready) begin
               op_d    = opcode_e'(mem_rdata[DATA_W-1 -: OpcodeW]);
               adr_d   = mem_rdata[ADDR_W-1:0];
               pc_d    = pc_q + 1'b1;
               re_d    = 1'b0;
               state_d = StDecode;
            end
         end
         StDecode: begin
            case (op_q)
               OpPush: begin
                  if (CheckEn && st_full) begin
                     fault = 1'b1;
                  end else begin
                     re_d    = 1'b1;
                     addr_d  = adr_q;
                     state_d = StMemRd;
                  end
               end
               OpJmp: begin
                  pc_d       = adr_q;
                  fetch_next = 1'b1;
               end
               OpPop: begin
                  // Write is launched early so POP completes alongside the pop itself.
                  if (!(CheckEn && st_empty)) begin
                     we_d    = 1'b1;
                     addr_d  = adr_q;
                     wdata_d = st_tos;
                  end
                  state_d = StPopA;
               end
               default: state_d = StPopA;
            endcase
         end
         StPopA: begin
            if (CheckEn && st_empty) begin
               fault = 1'b1;
            end else begin
               st_pop = 1'b1;
               a_d    = st_tos;
               case (op_q)
                  OpNot: state_d = StExec;
                  OpJz: begin
                     if (st_tos == '0) pc_d = adr_q;
                     fetch_next = 1'b1;
                  end
                  OpPop: begin
                     if (mem_ready) fetch_next = 1'b1;
                     else           state_d    = StMemWr;
                  end
                  default: state_d = StPopB;
               endcase
            end
         end
         StPopB: begin
            if (CheckEn && st_empty) begin
               fault = 1'b1;
            end else begin
               st_pop  = 1'b1;
               b_d     = st_tos;
               state_d = StExec;
            end
         end
         StExec: begin
            st_push    = 1'b1;
            st_din     = alu(op_q, a_q, b_q);
            fetch_next = 1'b1;
         end
         StMemRd: begin
            if (mem_ready) begin
               st_push    = 1'b1;
               fetch_next = 1'b1;
            end
         end
         StMemWr: begin
            if (mem_ready) fetch_next = 1'b1;
         end
         default: begin
            re_d = 1'b0;
            we_d = 1'b0;
         end
      endcase

      if (fetch_next) begin
         state_d = StFetch;
         re_d    = 1'b1;
         we_d    = 1'b0;
         addr_d  = pc_d;
      end
      if (fault) begin
         state_d  = StHalt;
         halted_d = 1'b1;
         err_d    = 1'b1;
         re_d     = 1'b0;
         we_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StFetch;
         pc_q     <= '0;
         op_q     <= OpAdd;
         adr_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         op_q     <= op_d;
         adr_q    <= adr_d;
         a_q      <= a_d;
         b_q      <= b_d;
         re_q     <= re_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_re    = re_q;
   assign mem_we    = we_q;
   assign pc_out    = pc_q;
   assign halted    = halted_q;
   assign stack_err = err_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed bench for stack_cpu_core: programs in a 32-word memory with optional wait states.
module tb_stack_cpu_core;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] mem_addr, pc_out;
   logic [7:0] mem_wdata, mem_rdata;
   logic       mem_re, mem_we, mem_ready, halted, stack_err;

   always #5 clk = ~clk;

   stack_cpu_core #(
      .DATA_W      (8),
      .ADDR_W      (5),
      .STACK_DEPTH (8)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .halted    (halted),
      .stack_err (stack_err)
   );

   // 16-bit build running a fixed SUB program from ROM with zero-wait memory.
   logic [4:0]  addr16, pc16;
   logic [15:0] wdata16, rdata16;
   logic        re16, we16, halted16, err16;
   logic [4:0]  w16_addr = '0;
   logic [15:0] w16_data = '0;

   stack_cpu_core #(
      .DATA_W      (16),
      .ADDR_W      (5),
      .STACK_DEPTH (8)
   ) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (addr16),
      .mem_wdata (wdata16),
      .mem_rdata (rdata16),
      .mem_re    (re16),
      .mem_we    (we16),
      .mem_ready (1'b1),
      .pc_out    (pc16),
      .halted    (halted16),
      .stack_err (err16)
   );

   always_comb begin
      rdata16 = '0;
      case (addr16)
         5'd0:    rdata16 = 16'h800A;
         5'd1:    rdata16 = 16'h800B;
         5'd2:    rdata16 = 16'h2000;
         5'd3:    rdata16 = 16'hA00C;
         5'd4:    rdata16 = 16'hC004;
         5'd10:   rdata16 = 16'h0003;
         5'd11:   rdata16 = 16'h0005;
         default: rdata16 = '0;
      endcase
   end

   always @(posedge clk) begin
      if (we16 && !rst) begin
         w16_addr <= addr16;
         w16_data <= wdata16;
      end
   end

   // Main memory, loader port, wait-state injector and activity monitors.
   logic [7:0] mem [32];
   logic       ld_en = 1'b0, stall_load = 1'b0, stall_hit;
   logic [4:0] ld_addr = '0, stall_addr = 5'd31;
   logic [7:0] ld_data = '0;
   int         stall_val = 0, stall_cnt = 0;
   int         cyc = 0, rd_cnt = 0, hold_cnt = 0;
   int         fetch_t[$];
   logic [4:0] fetch_a[$];
   logic [7:0] wlog[$];

   assign mem_rdata = mem[mem_addr];
   assign stall_hit = (mem_re || mem_we) && (mem_addr == stall_addr) && (stall_cnt != 0);
   assign mem_ready = !stall_hit;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (mem_we && mem_ready && !rst) begin
         mem[mem_addr] <= mem_wdata;
         wlog.push_back(mem_wdata);
      end
      if (stall_load)     stall_cnt <= stall_val;
      else if (stall_hit) stall_cnt <= stall_cnt - 1;
      if (mem_re && mem_ready && mem_addr == pc_out) begin
         fetch_t.push_back(cyc);
         fetch_a.push_back(mem_addr);
      end
      if (mem_re) rd_cnt <= rd_cnt + 1;
      if (mem_re && mem_addr == stall_addr) hold_cnt <= hold_cnt + 1;
   end

   int n_chk = 0, n_fail = 0;
   int fb = 0, wb = 0, base = 0;
   int exp_len [5] = '{3, 3, 5, 3, 2};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mem_load(input logic [4:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clk);
      #1;
      ld_en = 1'b0;
   endtask

   task automatic set_stall(input logic [4:0] a, input int n);
      stall_addr = a;
      stall_val  = n;
      stall_load = 1'b1;
      @(posedge clk);
      #1;
      stall_load = 1'b0;
   endtask

   task automatic begin_test();
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) mem_load(5'(i), 8'h00);
      set_stall(5'd31, 0);
   endtask

   task automatic go();
      fb  = fetch_t.size();
      wb  = wlog.size();
      rst = 1'b0;
   endtask

   task automatic wait_fetches(input int n, input int budget);
      for (int k = 0; k < budget && fetch_t.size() < fb + n; k++) begin
         @(posedge clk);
         #1;
      end
      check_eq("fetch_count_reached", 32'(fetch_t.size() >= fb + n), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_mem_re", 32'(mem_re), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check_eq("rst_pc", 32'(pc_out), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_stack_err", 32'(stack_err), 32'd0);

      // PUSH 10; PUSH 11; ADD; POP 12; JMP 4
      begin_test();
      mem_load(5'd0, 8'h8A); mem_load(5'd1, 8'h8B); mem_load(5'd2, 8'h00);
      mem_load(5'd3, 8'hAC); mem_load(5'd4, 8'hC4);
      mem_load(5'd10, 8'd3); mem_load(5'd11, 8'd5);
      go();
      wait_fetches(7, 200);
      for (int i = 0; i < 5; i++)
         check_eq($sformatf("add_prog_len%0d", i), 32'(fetch_t[fb+i+1] - fetch_t[fb+i]),
                  32'(exp_len[i]));
      check_eq("add_prog_loop_a", 32'(fetch_a[fb+5]), 32'd4);
      check_eq("add_prog_loop_b", 32'(fetch_a[fb+6]), 32'd4);
      check_eq("add_prog_result", 32'(mem[12]), 32'd8);

      // Same program with SUB: 3 - 5
      begin_test();
      mem_load(5'd0, 8'h8A); mem_load(5'd1, 8'h8B); mem_load(5'd2, 8'h20);
      mem_load(5'd3, 8'hAC); mem_load(5'd4, 8'hC4);
      mem_load(5'd10, 8'd3); mem_load(5'd11, 8'd5);
      go();
      wait_fetches(5, 200);
      check_eq("sub_len", 32'(fetch_t[fb+3] - fetch_t[fb+2]), 32'd5);
      check_eq("sub_result", 32'(mem[12]), 32'hFE);

      // JZ taken / not taken; a marker below the tested value shows one pop
      for (int t = 0; t < 2; t++) begin
         begin_test();
         mem_load(5'd0, 8'h8A); mem_load(5'd1, 8'h8B); mem_load(5'd2, 8'hF4);
         mem_load(5'd3, 8'hAD); mem_load(5'd4, 8'hC4);
         mem_load(5'd20, 8'hAC); mem_load(5'd21, 8'hD5);
         mem_load(5'd10, 8'h09); mem_load(5'd11, (t == 0) ? 8'h00 : 8'h07);
         go();
         wait_fetches(6, 200);
         check_eq($sformatf("jz%0d_len", t), 32'(fetch_t[fb+3] - fetch_t[fb+2]), 32'd3);
         check_eq($sformatf("jz%0d_target", t), 32'(fetch_a[fb+3]), (t == 0) ? 32'd20 : 32'd3);
         check_eq($sformatf("jz%0d_mem12", t), 32'(mem[12]), (t == 0) ? 32'h09 : 32'h00);
         check_eq($sformatf("jz%0d_mem13", t), 32'(mem[13]), (t == 0) ? 32'h00 : 32'h09);
      end

      // PUSH 10 with three wait states, then POP 12; JMP 2
      begin_test();
      mem_load(5'd0, 8'h8A); mem_load(5'd1, 8'hAC); mem_load(5'd2, 8'hC2);
      mem_load(5'd10, 8'h5A);
      set_stall(5'd10, 3);
      base = hold_cnt;
      go();
      wait_fetches(3, 200);
      check_eq("wait_push_len", 32'(fetch_t[fb+1] - fetch_t[fb]), 32'd6);
      check_eq("wait_pop_len", 32'(fetch_t[fb+2] - fetch_t[fb+1]), 32'd3);
      check_eq("wait_hold_cycles", 32'(hold_cnt - base), 32'd4);
      check_eq("wait_result", 32'(mem[12]), 32'h5A);

      // Nine PUSHes of 1..9, then eight POPs to address 30
      begin_test();
      for (int i = 0; i < 9; i++) begin
         mem_load(5'(i), 8'h80 | 8'(20 + i));
         mem_load(5'(20 + i), 8'(i + 1));
      end
      for (int i = 9; i < 17; i++) mem_load(5'(i), 8'hBE);
      mem_load(5'd17, 8'hD1);
      go();
      repeat (150) @(posedge clk);
      #1;
`ifdef STACK_CPU_STACK_CHECK_EN
      check_eq("ovf_halted", 32'(halted), 32'd1);
      check_eq("ovf_stack_err", 32'(stack_err), 32'd1);
      check_eq("ovf_pc", 32'(pc_out), 32'd9);
      check_eq("ovf_no_writes", 32'(wlog.size() - wb), 32'd0);
      base = rd_cnt;
      repeat (20) @(posedge clk);
      #1;
      check_eq("ovf_no_reads", 32'(rd_cnt - base), 32'd0);
      check_eq("ovf_mem_re", 32'(mem_re), 32'd0);
`else
      check_eq("wrap_halted", 32'(halted), 32'd0);
      check_eq("wrap_stack_err", 32'(stack_err), 32'd0);
      check_eq("wrap_writes", 32'(wlog.size() - wb), 32'd8);
      check_eq("wrap_first_pop", 32'(wlog[wb]), 32'd9);
      check_eq("wrap_second_pop", 32'(wlog[wb+1]), 32'd8);
      check_eq("wrap_last_pop", 32'(wlog[wb+7]), 32'd2);
`endif

      // Reset while a stalled POP write is outstanding
      begin_test();
      mem_load(5'd0, 8'h8A); mem_load(5'd1, 8'hAC); mem_load(5'd10, 8'h33);
      set_stall(5'd12, 20);
      go();
      for (int k = 0; k < 60 && !mem_we; k++) begin
         @(posedge clk);
         #1;
      end
      check_eq("rstw_we_seen", 32'(mem_we), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("rstw_we_drop", 32'(mem_we), 32'd0);
      check_eq("rstw_re_low", 32'(mem_re), 32'd0);
      check_eq("rstw_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;
      check_eq("rstw_no_write", 32'(mem[12]), 32'd0);
      go();
      wait_fetches(1, 20);
      check_eq("rstw_refetch_pc0", 32'(fetch_a[fb]), 32'd0);

      check_eq("w16_addr", 32'(w16_addr), 32'd12);
      check_eq("w16_sub_result", 32'(w16_data), 32'hFFFE);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
